axil_rd_mst: RTL and testbench

AXIL_RD_MST -- requirements
Module: axil_rd_mst

---
 rtl/axil_rd_mst_if.sv | 39 +++
 rtl/axil_rd_mst.sv | 143 ++++++++++++++
 tb/tb_axil_rd_mst.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/axil_rd_mst_if.sv
// Bundle of the core load-request/response channel and the AXI-lite AR/R channels.
// The master modport is the bridge's view; the slave modport is the view of the environment around it.
interface axil_rd_mst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_val;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_rdy;

  logic                  rsp_val;
  logic [DATA_WIDTH-1:0] rsp_dat;
  logic [1:0]            rsp_err;
  logic                  rsp_tmo;
  logic                  rsp_rdy;

  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic                  axi_arvalid;
  logic                  axi_arready;

  logic [DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rvalid;
  logic                  axi_rready;

  modport master (
    input  req_val, req_addr, rsp_rdy,
    input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
    output req_rdy, rsp_val, rsp_dat, rsp_err, rsp_tmo,
    output axi_araddr, axi_arvalid, axi_rready
  );

  modport slave (
    output req_val, req_addr, rsp_rdy,
    output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
    input  req_rdy, rsp_val, rsp_dat, rsp_err, rsp_tmo,
    input  axi_araddr, axi_arvalid, axi_rready
  );
endinterface

// File: rtl/axil_rd_mst.sv
// Single-outstanding AXI-lite read master: turns core load requests into AR/R transactions,
// with an R-channel timeout and a drain of the late beat that a timeout leaves behind.
module axil_rd_mst #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TMO_CYCLES = 255
) (
  input logic          clk,
  input logic          rst,
  axil_rd_mst_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TMO_CYCLES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_drain;
  logic                  w_drain_nxt;
  logic [15:0]           r_cnt;
  logic [15:0]           w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [DATA_WIDTH-1:0] w_dat_nxt;
  logic [1:0]            r_err;
  logic [1:0]            w_err_nxt;
  logic                  r_tmo;
  logic                  w_tmo_nxt;

  logic                  w_req_fire;
  logic                  w_terminal;
  logic                  w_drain_beat;

  // Handshake decodes from registered state only, so no input reaches req_rdy or axi_arvalid.
  assign bus.req_rdy     = (r_state == IDLE) && !r_drain;
  assign bus.axi_arvalid = (r_state == ADDR);
  assign bus.axi_rready  = (r_state == DATA) || r_drain;
  assign bus.rsp_val     = (r_state == RESP);
  assign bus.axi_araddr  = r_addr;
  assign bus.rsp_dat     = r_dat;
  assign bus.rsp_err     = r_err;
  assign bus.rsp_tmo     = r_tmo;

  assign w_req_fire   = bus.req_val && bus.req_rdy;
  assign w_terminal   = (r_cnt == TMO_LIMIT);
  // A beat seen outside DATA while draining belongs to the timed-out transaction.
  assign w_drain_beat = r_drain && (r_state != DATA) && bus.axi_rvalid;

  // Next-state, counter, capture and drain logic.
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_dat_nxt   = r_dat;
    w_err_nxt   = r_err;
    w_tmo_nxt   = r_tmo;

    if (w_drain_beat) begin
      w_drain_nxt = 1'b0;
    end else begin
      w_drain_nxt = r_drain;
    end

    case (r_state)
      IDLE: begin
        if (w_req_fire) begin
          w_addr_nxt  = bus.req_addr;
          w_state_nxt = ADDR;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ADDR: begin
        if (bus.axi_arready) begin
          w_cnt_nxt   = 16'd0;
          w_state_nxt = DATA;
        end else begin
          w_state_nxt = ADDR;
        end
      end
      DATA: begin
        // A beat on the terminal-count cycle still wins over the timeout.
        if (bus.axi_rvalid) begin
          w_dat_nxt   = bus.axi_rdata;
          w_err_nxt   = bus.axi_rresp;
          w_tmo_nxt   = 1'b0;
          w_state_nxt = RESP;
        end else if (w_terminal) begin
          w_dat_nxt   = {DATA_WIDTH{1'b0}};
          w_err_nxt   = 2'b00;
          w_tmo_nxt   = 1'b1;
          w_drain_nxt = 1'b1;
          w_state_nxt = RESP;
        end else if (r_cnt != 16'hFFFF) begin
          w_cnt_nxt   = r_cnt + 16'd1;
          w_state_nxt = DATA;
        end else begin
          w_state_nxt = DATA;
        end
      end
      RESP: begin
        if (bus.rsp_rdy) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_drain <= 1'b0;
      r_cnt   <= 16'd0;
      r_addr  <= {ADDR_WIDTH{1'b0}};
      r_dat   <= {DATA_WIDTH{1'b0}};
      r_err   <= 2'b00;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_dat   <= w_dat_nxt;
      r_err   <= w_err_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

endmodule

// File: tb/tb_axil_rd_mst.sv
// Self-checking bench for axil_rd_mst: a fixed vector table, randomized transactions scored
// against a behavioural model, and a reset-during-DATA sequence.
module tb_axil_rd_mst;

  localparam int TMO = 4;

  typedef struct {
    logic [31:0] addr;
    int          ar_d;
    int          r_d;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          rsp_d;
    logic [31:0] e_dat;
    logic [1:0]  e_err;
    logic        e_tmo;
    int          e_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t tbl[7];

  always #5 clk = ~clk;

  axil_rd_mst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  axil_rd_mst #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TMO_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Behavioural reference: the beat wins if it arrives by DATA cycle TMO, else a timeout response.
  function automatic vec_t model(input vec_t v);
    vec_t m;
    m = v;
    if (v.r_d <= TMO) begin
      m.e_dat = v.rdata;
      m.e_err = v.rresp;
      m.e_tmo = 1'b0;
      m.e_lat = 3 + v.ar_d + v.r_d;
    end else begin
      m.e_dat = 32'h0;
      m.e_err = 2'b00;
      m.e_tmo = 1'b1;
      m.e_lat = 3 + v.ar_d + TMO;
    end
    return m;
  endfunction

  task automatic idle_inputs();
    bus.req_val     = 1'b0;
    bus.req_addr    = 32'h0;
    bus.rsp_rdy     = 1'b0;
    bus.axi_arready = 1'b0;
    bus.axi_rvalid  = 1'b0;
    bus.axi_rdata   = 32'h0;
    bus.axi_rresp   = 2'b00;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int   wait_n, ar_cnt, r_idx, rsp_cnt, lat;
    int   bad_addr, bad_rdy, bad_stab, bad_rready;
    logic rsp_seen, rsp_done, hs_now, beat_driven, beat_done, over;
    logic [31:0] g_dat;
    logic [1:0]  g_err;
    logic        g_tmo;
    ar_cnt = 0; r_idx = -1; rsp_cnt = 0; lat = -1;
    bad_addr = 0; bad_rdy = 0; bad_stab = 0; bad_rready = 0;
    rsp_seen = 1'b0; rsp_done = 1'b0; hs_now = 1'b0; beat_driven = 1'b0; beat_done = 1'b0;
    g_dat = 32'h0; g_err = 2'b00; g_tmo = 1'b0;
    over = 1'b1;
    wait_n = 0;
    @(negedge clk);
    while (!bus.req_rdy && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, ".req_rdy_start"}, 64'(bus.req_rdy), 64'd1);
    bus.req_val  = 1'b1;
    bus.req_addr = v.addr;
    @(posedge clk);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (hs_now) rsp_done = 1'b1;
      if (beat_driven) beat_done = 1'b1;
      if (bus.axi_arvalid) begin
        ar_cnt++;
        if (bus.axi_araddr !== v.addr) bad_addr++;
        if (bus.req_rdy) bad_rdy++;
      end
      if (v.e_tmo && !beat_done && bus.req_rdy) bad_rdy++;
      if (bus.rsp_val) begin
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          lat   = cyc;
          g_dat = bus.rsp_dat;
          g_err = bus.rsp_err;
          g_tmo = bus.rsp_tmo;
        end else if ({bus.rsp_dat, bus.rsp_err, bus.rsp_tmo} !== {g_dat, g_err, g_tmo}) begin
          bad_stab++;
        end
        rsp_cnt++;
      end
      if (rsp_done && beat_done) begin
        over = 1'b0;
        break;
      end
      bus.axi_arready = bus.axi_arvalid && (ar_cnt == v.ar_d + 1);
      bus.axi_rvalid  = 1'b0;
      bus.axi_rdata   = $urandom;
      bus.axi_rresp   = 2'($urandom_range(0, 3));
      if (r_idx >= 0) begin
        if (r_idx == v.r_d) begin
          bus.axi_rvalid = 1'b1;
          bus.axi_rdata  = v.rdata;
          bus.axi_rresp  = v.rresp;
          beat_driven    = 1'b1;
          if (!bus.axi_rready) bad_rready++;
        end
        r_idx++;
      end
      if (bus.axi_arready) r_idx = 0;
      hs_now      = bus.rsp_val && (rsp_cnt == v.rsp_d + 1);
      bus.rsp_rdy = bus.rsp_val ? hs_now : 1'($urandom_range(0, 1));
      bus.req_val = bus.axi_arvalid ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.req_addr = $urandom;
    end
    idle_inputs();
    check({tag, ".budget"},     64'(over),       64'd0);
    check({tag, ".rsp_dat"},    64'(g_dat),      64'(v.e_dat));
    check({tag, ".rsp_err"},    64'(g_err),      64'(v.e_err));
    check({tag, ".rsp_tmo"},    64'(g_tmo),      64'(v.e_tmo));
    check({tag, ".latency"},    64'(lat),        64'(v.e_lat));
    check({tag, ".ar_cycles"},  64'(ar_cnt),     64'(v.ar_d + 1));
    check({tag, ".rsp_cycles"}, 64'(rsp_cnt),    64'(v.rsp_d + 1));
    check({tag, ".araddr"},     64'(bad_addr),   64'd0);
    check({tag, ".req_rdy_busy"}, 64'(bad_rdy),  64'd0);
    check({tag, ".rsp_stable"}, 64'(bad_stab),   64'd0);
    check({tag, ".rready"},     64'(bad_rready), 64'd0);
    check({tag, ".req_rdy_end"}, 64'(bus.req_rdy), 64'd1);
  endtask

  initial begin
    vec_t v;
    int   rsp_seen_n;
    rst = 1'b1;
    idle_inputs();

    //                addr          ar  r  rdata         rresp  rsp  e_dat         e_err  e_tmo  e_lat
    tbl[0] = '{32'h10000000,  0, 0, 32'hDEADBEEF, 2'b00, 0, 32'hDEADBEEF, 2'b00, 1'b0,  3};
    tbl[1] = '{32'h10000004,  0, 0, 32'h00000000, 2'b10, 0, 32'h00000000, 2'b10, 1'b0,  3};
    tbl[2] = '{32'h20000000, 10, 1, 32'hA5A5A5A5, 2'b01, 0, 32'hA5A5A5A5, 2'b01, 1'b0, 14};
    tbl[3] = '{32'h30000008,  0, 6, 32'h12345678, 2'b00, 1, 32'h00000000, 2'b00, 1'b1,  7};
    tbl[4] = '{32'h4000000C,  2, 4, 32'hCAFEF00D, 2'b11, 0, 32'hCAFEF00D, 2'b11, 1'b0,  9};
    tbl[5] = '{32'h50000010,  0, 5, 32'h87654321, 2'b01, 5, 32'h00000000, 2'b00, 1'b1,  7};
    tbl[6] = '{32'h60000000,  1, 2, 32'h0BADF00D, 2'b00, 5, 32'h0BADF00D, 2'b00, 1'b0,  6};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.held", {bus.req_rdy, bus.rsp_val, bus.axi_arvalid, bus.axi_rready,
                         bus.axi_araddr, bus.rsp_dat, bus.rsp_err, bus.rsp_tmo},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0});
    rst = 1'b0;
    @(negedge clk);
    check("reset.after", {bus.req_rdy, bus.rsp_val, bus.axi_arvalid, bus.axi_rready,
                          bus.axi_araddr, bus.rsp_dat, bus.rsp_err, bus.rsp_tmo},
          {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0});

    for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 30; i++) begin
      v.addr  = $urandom;
      v.ar_d  = ($urandom_range(0, 7) == 0) ? 12 : $urandom_range(0, 3);
      v.r_d   = $urandom_range(0, TMO + 4);
      v.rdata = $urandom;
      v.rresp = 2'($urandom_range(0, 3));
      v.rsp_d = $urandom_range(0, 3);
      v.e_dat = 32'h0; v.e_err = 2'b00; v.e_tmo = 1'b0; v.e_lat = 0;
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

    // Reset during DATA must abort the read without a response.
    @(negedge clk);
    bus.req_val  = 1'b1;
    bus.req_addr = 32'h70000000;
    @(negedge clk);
    bus.req_val     = 1'b0;
    bus.axi_arready = 1'b1;
    @(negedge clk);
    bus.axi_arready = 1'b0;
    check("rstdata.in_data", 64'(bus.axi_rready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstdata.after", {bus.rsp_val, bus.axi_rready, bus.req_rdy, bus.axi_arvalid},
          {1'b0, 1'b0, 1'b1, 1'b0});
    rst = 1'b0;
    rsp_seen_n = 0;
    for (int i = 0; i < 8; i++) begin
      bus.axi_rvalid = (i == 1);
      bus.axi_rdata  = 32'hFEEDFACE;
      bus.rsp_rdy    = 1'b1;
      @(negedge clk);
      if (bus.rsp_val) rsp_seen_n++;
    end
    idle_inputs();
    check("rstdata.no_rsp", 64'(rsp_seen_n), 64'd0);
    check("rstdata.rdy", 64'(bus.req_rdy), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
